// File: rtl/qkv_row_fetch_pkg.sv
// Shared types for the Q/K/V row fetch engine: memory bus types, FSM states,
// row container and the tag-table entry layout.
package qkv_row_fetch_pkg;

  localparam int BLOCKS_PER_ROW = 8;
  localparam int ROW_IDX_W      = 16;
  localparam int NUM_SLOTS      = 2;
  localparam int ROW_BYTES      = 64;
  localparam int ADDR_W         = 32;
  localparam int TAG_W          = 4;
  localparam int BEAT_W         = $clog2(BLOCKS_PER_ROW);

  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [63:0]          mem_block_t;
  typedef logic [TAG_W-1:0]     mem_tag_t;
  typedef logic [ROW_IDX_W-1:0] row_idx_t;
  typedef logic [BEAT_W-1:0]    beat_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_command_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } fetch_state_t;

  typedef logic [BLOCKS_PER_ROW-1:0][63:0] row_data_t;

  typedef struct packed {
    logic  valid;
    logic  slot;
    beat_t beat;
  } tag_entry_t;

  // Byte address of one beat; wraps modulo 2^32 by construction.
  function automatic addr_t beat_addr(addr_t base, row_idx_t row, beat_t beat);
    return base + (addr_t'(row) * addr_t'(ROW_BYTES)) + (addr_t'(beat) << 3);
  endfunction

endpackage

// File: rtl/qkv_row_fetch_if.sv
// Memory-port and row-stream signals of the fetch engine, grouped as one bundle.
// Row stream: a row transfers on a cycle where row_valid && row_ready; once
// row_valid rises, row_data/row_idx hold until that transfer happens.
interface qkv_row_fetch_if;
  import qkv_row_fetch_pkg::*;

  logic         mem_grant;
  mem_command_t mem_command;
  addr_t        mem_addr;
  mem_tag_t     mem_transaction_tag;
  mem_block_t   mem_data;
  mem_tag_t     mem_data_tag;
  logic         row_valid;
  logic         row_ready;
  row_data_t    row_data;
  row_idx_t     row_idx;

  modport master (
    input  mem_grant, mem_transaction_tag, mem_data, mem_data_tag, row_ready,
    output mem_command, mem_addr, row_valid, row_data, row_idx
  );

  modport slave (
    output mem_grant, mem_transaction_tag, mem_data, mem_data_tag, row_ready,
    input  mem_command, mem_addr, row_valid, row_data, row_idx
  );

endinterface

// File: rtl/qkv_row_fetch_buf.sv
// Two-slot row assembly buffer: per-beat received bits, slot allocation flags
// and the in-order delivery pointer.
module qkv_row_fetch_buf
  import qkv_row_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_slot,
  input  beat_t                wr_beat,
  input  mem_block_t           wr_data,
  input  logic                 alloc_en,
  input  logic                 alloc_slot,
  output logic [NUM_SLOTS-1:0] slot_alloc,
  output logic                 row_valid,
  input  logic                 row_ready,
  output row_data_t            row_data,
  output logic                 row_fire
);

  row_data_t                 data_q [NUM_SLOTS];
  logic [BLOCKS_PER_ROW-1:0] rcvd_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]      alloc_q;
  logic                      out_slot;

  assign row_valid  = &rcvd_q[out_slot];
  assign row_data   = data_q[out_slot];
  assign row_fire   = row_valid && row_ready;
  assign slot_alloc = alloc_q;

  // A full slot is never written, so the presented row stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) rcvd_q[s] <= '0;
      alloc_q  <= '0;
      out_slot <= 1'b0;
    end else begin
      if (row_fire) begin
        rcvd_q[out_slot]  <= '0;
        alloc_q[out_slot] <= 1'b0;
        out_slot          <= ~out_slot;
      end
      if (wr_en) rcvd_q[wr_slot][wr_beat] <= 1'b1;
      if (alloc_en) alloc_q[alloc_slot] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_slot][wr_beat] <= wr_data;
  end

endmodule

// File: rtl/qkv_row_fetch.sv
// Row fetch engine: issues MEM_LOADs for a contiguous run of 64 B rows, tracks
// outstanding beats by tag and streams assembled rows out in order.
module qkv_row_fetch
  import qkv_row_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  addr_t           base_addr,
  input  row_idx_t        num_rows,
  output logic            busy,
  output logic            done,
  output fetch_state_t    dbg_state,
  qkv_row_fetch_if.master bus
);

  fetch_state_t         state, next_state;
  addr_t                base_q;
  row_idx_t             rows_q, issue_row, out_row;
  beat_t                issue_beat;
  logic                 issue_slot;
  tag_entry_t           tag_tbl [2**TAG_W];
  tag_entry_t           ret_entry;
  logic [NUM_SLOTS-1:0] slot_alloc;
  logic                 accept, last_beat, ret_hit, row_fire;
  mem_command_t         cmd;

  assign ret_entry = tag_tbl[bus.mem_data_tag];
  assign ret_hit   = (bus.mem_data_tag != '0) && ret_entry.valid;
  assign last_beat = (issue_beat == beat_t'(BLOCKS_PER_ROW - 1));
  // Issuing stalls while the issue slot still holds a row not yet handed off.
  assign cmd       = (state == FETCH && !slot_alloc[issue_slot]) ? MEM_LOAD : MEM_NONE;
  assign accept    = (cmd == MEM_LOAD) && bus.mem_grant && (bus.mem_transaction_tag != '0);

  assign bus.mem_command = cmd;
  assign bus.row_idx     = out_row;
  assign dbg_state       = state;

  always_comb begin
    next_state   = state;
    bus.mem_addr = '0;
    case (state)
      IDLE:  if (start) next_state = (num_rows == '0) ? FIN : FETCH;
      FETCH: begin
        bus.mem_addr = beat_addr(base_q, issue_row, issue_beat);
        if (accept && last_beat && (issue_row + row_idx_t'(1) == rows_q)) next_state = DRAIN;
      end
      DRAIN: if (out_row == rows_q) next_state = FIN;
      FIN:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      base_q     <= '0;
      rows_q     <= '0;
      issue_row  <= '0;
      issue_beat <= '0;
      issue_slot <= 1'b0;
      out_row    <= '0;
    end else begin
      state <= next_state;
      done  <= (state == FIN);
      if (state == IDLE && start) begin
        busy       <= 1'b1;
        base_q     <= base_addr;
        rows_q     <= num_rows;
        issue_row  <= '0;
        issue_beat <= '0;
        out_row    <= '0;
      end else if (state == FIN) begin
        busy <= 1'b0;
      end
      if (accept) begin
        issue_beat <= last_beat ? beat_t'(0) : issue_beat + beat_t'(1);
        if (last_beat) begin
          issue_row  <= issue_row + row_idx_t'(1);
          issue_slot <= ~issue_slot;
        end
      end
      if (row_fire) out_row <= out_row + row_idx_t'(1);
    end
  end

  // Return is retired before a same-cycle allocation so the new owner keeps the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < 2**TAG_W; t++) tag_tbl[t] <= '0;
    end else begin
      if (ret_hit) tag_tbl[bus.mem_data_tag].valid <= 1'b0;
      if (accept) tag_tbl[bus.mem_transaction_tag] <= '{valid: 1'b1, slot: issue_slot, beat: issue_beat};
    end
  end

  qkv_row_fetch_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (ret_hit),
    .wr_slot    (ret_entry.slot),
    .wr_beat    (ret_entry.beat),
    .wr_data    (bus.mem_data),
    .alloc_en   (accept && last_beat),
    .alloc_slot (issue_slot),
    .slot_alloc (slot_alloc),
    .row_valid  (bus.row_valid),
    .row_ready  (bus.row_ready),
    .row_data   (bus.row_data),
    .row_fire   (row_fire)
  );

endmodule

// File: tb/tb_qkv_row_fetch.sv
// Bench for qkv_row_fetch: tagged memory model with random latency/grant,
// expected-row and expected-address queues, directed and random jobs.
module tb_qkv_row_fetch;
  import qkv_row_fetch_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  addr_t        base_addr;
  row_idx_t     num_rows;
  logic         busy, done;
  fetch_state_t dbg_state;

  qkv_row_fetch_if bus();

  qkv_row_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    mem_tag_t tag;
    addr_t    addr;
    int       due;
  } pend_t;

  int           checks = 0;
  int           failures = 0;
  logic [511:0] exp_q[$];
  addr_t        exp_addr_q[$];
  pend_t        pend_q[$];
  logic [15:0]  in_use = '0;
  int           ncyc = 0;
  int           loads = 0, done_cnt = 0, busy_cyc = 0, exp_idx = 0;
  time          t_start = 0, t_done = 0;
  int           lat_min = 2, lat_max = 2, ready_mode = 1;
  bit           grant_rand = 0, inject_en = 0;
  addr_t        hold_addr = '0;
  int           hold_left = 0, hold_kind = 0;
  bit           hold_on = 0, hold_first = 0;
  logic         prev_stall = 1'b0;
  logic [511:0] prev_data = '0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic mem_block_t mem_word(addr_t a);
    return {a ^ 32'hC0DE_0000, ~a};
  endfunction

  // Tag 9 is reserved for foreign-requester traffic and never handed to the DUT.
  function automatic mem_tag_t pick_free();
    int off = $urandom_range(0, 14);
    for (int k = 0; k < 15; k++) begin
      int t = 1 + (off + k) % 15;
      if (t != 9 && !in_use[t]) return mem_tag_t'(t);
    end
    return '0;
  endfunction

  // ---------------- memory model + row monitor ----------------
  always @(negedge clk) begin
    int       idx;
    int       lat;
    pend_t    p;
    mem_tag_t tt;
    logic     g;
    idx = -1;
    foreach (pend_q[i]) if (idx < 0 && pend_q[i].due <= ncyc) idx = i;
    if (idx >= 0) begin
      p = pend_q[idx];
      pend_q.delete(idx);
      in_use[p.tag] = 1'b0;
      bus.mem_data_tag = p.tag;
      bus.mem_data     = mem_word(p.addr);
    end else if (inject_en && $urandom_range(0, 2) == 0) begin
      bus.mem_data_tag = 4'd9;
      bus.mem_data     = {$urandom, $urandom};
    end else begin
      bus.mem_data_tag = '0;
      bus.mem_data     = {$urandom, $urandom};
    end

    g  = grant_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    tt = pick_free();
    if (hold_left > 0 && !hold_on && bus.mem_command == MEM_LOAD && bus.mem_addr == hold_addr) begin
      hold_on    = 1'b1;
      hold_first = 1'b1;
    end
    if (hold_on) begin
      if (!hold_first) begin
        check("hold_addr", bus.mem_addr, hold_addr);
        check("hold_cmd", bus.mem_command, MEM_LOAD);
      end
      hold_first = 1'b0;
      if (hold_kind == 0) begin
        g  = 1'b1;
        tt = '0;
      end else begin
        g  = 1'b0;
        tt = mem_tag_t'($urandom_range(1, 15));
      end
      hold_left--;
      if (hold_left == 0) hold_on = 1'b0;
    end
    if (!rst && bus.mem_command == MEM_LOAD && g && tt != '0) begin
      loads++;
      check("load_expected", exp_addr_q.size() != 0, 1);
      if (exp_addr_q.size() != 0) check("load_addr", bus.mem_addr, exp_addr_q.pop_front());
      in_use[tt] = 1'b1;
      lat = $urandom_range(lat_min, lat_max);
      p.tag = tt; p.addr = bus.mem_addr; p.due = ncyc + lat;
      pend_q.push_back(p);
    end
    bus.mem_grant           = g;
    bus.mem_transaction_tag = tt;

    case (ready_mode)
      0:       bus.row_ready = 1'b0;
      1:       bus.row_ready = 1'b1;
      default: bus.row_ready = ($urandom_range(0, 1) == 1);
    endcase
    if (prev_stall && bus.row_valid) check("row_stable", bus.row_data, prev_data);
    if (!rst && bus.row_valid && bus.row_ready) begin
      check("row_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("row_data", bus.row_data, exp_q.pop_front());
      check("row_idx", bus.row_idx, exp_idx);
      exp_idx++;
    end
    prev_stall = bus.row_valid && !bus.row_ready;
    prev_data  = bus.row_data;

    if (done) begin
      if (done_cnt == 0) t_done = $time;
      done_cnt++;
      check("busy_at_done", busy, 0);
    end
    if (busy) busy_cyc++;
    ncyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input addr_t base, input int n);
    logic [511:0] row;
    addr_t        a;
    exp_q.delete();
    exp_addr_q.delete();
    for (int r = 0; r < n; r++) begin
      row = '0;
      for (int b = 0; b < BLOCKS_PER_ROW; b++) begin
        a = base + addr_t'(r * ROW_BYTES + b * 8);
        exp_addr_q.push_back(a);
        row[64*b +: 64] = mem_word(a);
      end
      exp_q.push_back(row);
    end
    loads = 0; done_cnt = 0; busy_cyc = 0; exp_idx = 0;
    @(negedge clk);
    start = 1'b1; base_addr = base; num_rows = row_idx_t'(n);
    t_start = $time;
    @(negedge clk);
    start = 1'b0; base_addr = $urandom; num_rows = row_idx_t'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int n, input int timeout);
    int k = 0;
    while (done_cnt == 0 && k < timeout) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done_cnt != 0, 1);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("load_count", loads, 8 * n);
    check("rows_left", exp_q.size(), 0);
    check("busy_idle", busy, 0);
    check("state_idle", dbg_state, IDLE);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cmd"}, bus.mem_command, MEM_NONE);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_row_valid"}, bus.row_valid, 0);
    check({tag, "_row_idx"}, bus.row_idx, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // single row, fixed latency
    lat_min = 3; lat_max = 3;
    start_job(32'h0000_1000, 1);
    wait_done(1, 200);

    // backpressure: only two rows may be in flight
    lat_min = 1; lat_max = 4; ready_mode = 0;
    start_job(32'h0000_8000, 3);
    repeat (80) @(negedge clk);
    check("bp_loads", loads, 16);
    check("bp_cmd", bus.mem_command, MEM_NONE);
    check("bp_row_valid", bus.row_valid, 1);
    ready_mode = 1;
    wait_done(3, 300);

    // no tag returned for 3 cycles on beat 2 of row 0
    hold_addr = 32'h0000_2010; hold_kind = 0; hold_left = 3;
    start_job(32'h0000_2000, 2);
    wait_done(2, 300);
    check("hold_tag_used", hold_left, 0);

    // grant withheld for 5 cycles mid-row, plus foreign tag traffic
    hold_addr = 32'h0000_3018; hold_kind = 1; hold_left = 5; inject_en = 1;
    start_job(32'h0000_3000, 2);
    wait_done(2, 300);
    check("nogrant_used", hold_left, 0);
    inject_en = 0;

    // empty job
    start_job(32'h0000_4000, 0);
    wait_done(0, 20);
    check("empty_done_time", t_done - t_start, 20);
    check("empty_busy_cycles", busy_cyc, 1);

    // reset mid-job with stale tags returning afterwards
    lat_min = 8; lat_max = 10;
    start_job(32'h0000_5000, 2);
    for (int k = 0; k < 100 && loads < 4; k++) @(negedge clk);
    check("abort_loads_seen", loads >= 4, 1);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete(); exp_addr_q.delete(); hold_left = 0;
    check_reset_outputs("abort");
    rst = 1'b0;
    done_cnt = 0;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_row_valid", bus.row_valid, 0);
    check("abort_busy", busy, 0);
    lat_min = 1; lat_max = 3;
    start_job(32'h0000_6000, 1);
    wait_done(1, 200);

    // random jobs: random grant, latency, backpressure, foreign tags, address wrap
    grant_rand = 1; ready_mode = 2; inject_en = 1; lat_min = 1; lat_max = 7;
    start_job(32'hFFFF_FF80, 3);
    wait_done(3, 600);
    for (int j = 0; j < 5; j++) begin
      int    n;
      addr_t b;
      n = $urandom_range(1, 4);
      b = addr_t'($urandom) & 32'hFFFF_FFC0;
      start_job(b, n);
      wait_done(n, 600);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
